// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined segment adder.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// adder_seg: combinational SEG-bit ripple-carry slice used by each pipeline stage.
module adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG = seg_width(DEF_WIDTH, DEF_STAGES)
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SEG];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, one SEG-bit ripple slice per stage, valid/ready on both sides.
// Optional subtract support is enabled by defining PIPE_ADDER_SUB_EN.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic             ovf_o
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t           st      [STAGES];
  stage_t           prev    [STAGES];
  logic [SEG-1:0]   seg_s   [STAGES];
  logic             seg_co  [STAGES];
  logic [STAGES:0]  ready;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

`ifdef PIPE_ADDER_SUB_EN
  assign b_eff = sub_i ? ~b_i : b_i;
  assign cin   = c_i ^ sub_i;
`else
  assign b_eff = b_i;
  assign cin   = c_i;
`endif

  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !st[k].valid || ready[k+1];
    end
  end

  assign in_ready = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign prev[k] = '{valid: in_valid, carry: cin, a: a_i, b: b_eff, sum: '0};
    end else begin : g_body
      assign prev[k] = st[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a    (prev[k].a[k*SEG +: SEG]),
      .b    (prev[k].b[k*SEG +: SEG]),
      .cin  (prev[k].carry),
      .s    (seg_s[k]),
      .cout (seg_co[k])
    );
  end

  // Segment k of the incoming sum is still zero, so OR-ing the new slice in is an insert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          st[k].valid <= prev[k].valid;
          if (prev[k].valid) begin
            st[k].carry <= seg_co[k];
            st[k].a     <= prev[k].a;
            st[k].b     <= prev[k].b;
            st[k].sum   <= prev[k].sum | (WIDTH'(seg_s[k]) << (k * SEG));
          end
        end
      end
    end
  end

  assign out_valid = st[STAGES-1].valid;
  assign sum_o     = st[STAGES-1].sum;
  assign co_o      = st[STAGES-1].carry;
  assign ovf_o     = (st[STAGES-1].a[WIDTH-1] == st[STAGES-1].b[WIDTH-1]) &&
                     (st[STAGES-1].sum[WIDTH-1] != st[STAGES-1].a[WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: queue-based reference model plus directed literal checks.
module tb_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_i;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_o;
  logic             co_o;
  logic             ovf_o;

  int passed = 0;
  int total  = 0;
  int out_count = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int cyc = 0;
  logic [17:0] q[$];

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .c_i       (c_i),
`ifdef PIPE_ADDER_SUB_EN
    .sub_i     (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .co_o      (co_o),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {ovf, co, sum} straight from the arithmetic definition.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                       input logic c, input logic s);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ci;
    bb   = s ? ~b : b;
    ci   = c ^ s;
    full = {1'b0, a} + {1'b0, bb} + 17'(ci);
    return {(a[15] == bb[15]) && (full[15] != a[15]), full};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL stream: output %0h with no pending input", sum_o);
        end else begin
          chk("stream", 64'({ovf_o, co_o, sum_o}), 64'(q.pop_front()));
        end
        if (out_count == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_count++;
      end
`ifdef PIPE_ADDER_SUB_EN
      if (in_valid && in_ready) q.push_back(model(a_i, b_i, c_i, sub));
`else
      if (in_valid && in_ready) q.push_back(model(a_i, b_i, c_i, 1'b0));
`endif
    end
  end

  task automatic single(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] e_sum,
                        input logic e_co, input logic e_ovf);
    int lat;
    in_valid = 1'b1; a_i = a; b_i = b; c_i = c; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(STAGES - 1));
    chk({nm, "_sum"}, 64'(sum_o), 64'(e_sum));
    chk({nm, "_co"}, 64'(co_o), 64'(e_co));
    chk({nm, "_ovf"}, 64'(ovf_o), 64'(e_ovf));
    @(posedge clk); #1;
    chk({nm, "_no_dup"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    int acc;
    int rdy_low;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; c_i = 1'b0; sub = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum_o), 64'(0));
    chk("rst_co_ovf", 64'({co_o, ovf_o}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    single("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    single("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("carry_in", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    single("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef PIPE_ADDER_SUB_EN
    single("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

    // back-to-back random stream
    out_count = 0; rdy_low = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      if (!in_ready) rdy_low++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; sub = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    #1;
    chk("stream_count", 64'(out_count), 64'(100));
    chk("stream_consecutive", 64'(last_cyc - first_cyc), 64'(99));
    chk("stream_in_ready", 64'(rdy_low), 64'(0));

    // fill pipeline with downstream stalled
    out_ready = 1'b0; out_count = 0; acc = 0; c_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      a_i = 16'(32'h1000 * (k + 1));
      b_i = 16'(32'h0011 * (k + 1));
      if (!in_ready) break;
      acc++;
      @(posedge clk); #1;
    end
    chk("stall_accepted", 64'(acc), 64'(STAGES));
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      chk("stall_sum_hold", 64'(sum_o), 64'(16'h1011));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("release_count", 64'(out_count), 64'(STAGES + 1));
    chk("release_drained", 64'(q.size()), 64'(0));
    chk("release_idle", 64'(out_valid), 64'(0));

    // reset with three operations in flight
    out_count = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a_i = 16'(32'h0111 * (k + 1)); b_i = 16'h2222; c_i = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b0; c_i = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_sum", 64'(sum_o), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_no_output", 64'(out_count), 64'(0));
    single("post_rst", 16'h0A0A, 16'h0101, 1'b0, 1'b0, 16'h0B0B, 1'b0, 1'b0);
    chk("post_rst_queue", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
